// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and parity modes.
package uart_pkg;

   // Frame-level FSM states; any other encoding is treated as illegal.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // Parity mode: the value the XOR of data bits plus parity bit must equal.
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // True when the XOR over data and parity bits disagrees with the mode.
   function automatic logic parity_bad(input logic xor_all, input logic mode);
      return xor_all != mode;
   endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// Receiver-side bundle: serial line and oversample strobe in, framed word out.
interface uart_rx_framed_if #(
   parameter int DBITS = 8
);
   logic             rx;
   logic             sTick;
   logic             rxReady;
   logic [DBITS-1:0] rxData;
   logic             rxValid;
   logic             parityErr;
   logic             frameErr;
   logic             overrun;
   logic             busy;

   // Receiver produces words.
   modport master (
      input  rx, sTick, rxReady,
      output rxData, rxValid, parityErr, frameErr, overrun, busy
   );

   // Line driver / word consumer.
   modport slave (
      output rx, sTick, rxReady,
      input  rxData, rxValid, parityErr, frameErr, overrun, busy
   );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer; resets to 1 so an idle line never looks like a start bit.
module uart_sync2 (
   input  logic clk,
   input  logic resetn,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   logic sync_q;

   // Double-register the asynchronous input.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with optional parity, 1 or 2 stop bits and a
// single-word holding register with overrun reporting.
module uart_rx_framed
   import uart_pkg::*;
#(
   parameter int DBITS      = 8,
   parameter int OSR        = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input logic                 clk,
   input logic                 resetn,
   uart_rx_framed_if.master    bus
);
   localparam int S_W = $clog2(OSR);
   localparam int N_W = $clog2(DBITS);
   localparam logic [S_W-1:0] S_MID       = S_W'(OSR / 2 - 1);
   localparam logic [S_W-1:0] S_LAST      = S_W'(OSR - 1);
   localparam logic [N_W-1:0] N_LAST      = N_W'(DBITS - 1);
   localparam logic [N_W-1:0] N_STOP_LAST = N_W'(STOP_BITS - 1);
   localparam logic           PAR_MODE    = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   logic             rxs;
   uart_state_e      state_q, state_d;
   logic [S_W-1:0]   s_q, s_d;
   logic [N_W-1:0]   n_q, n_d;
   logic [DBITS-1:0] shreg_q, shreg_d;
   logic             fperr_q, fperr_d;   // parity error of the frame in flight
   logic             fferr_q, fferr_d;   // stop-bit error of the frame in flight
   logic             done;               // last stop bit sampled this cycle
   logic [DBITS-1:0] rxdata_q, rxdata_d;
   logic             rxvalid_q, rxvalid_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             overrun_q, overrun_d;

   uart_sync2 u_sync_rx (
      .clk    (clk),
      .resetn (resetn),
      .d_i    (bus.rx),
      .q_o    (rxs)
   );

   // Frame FSM next state: tick/bit counting and per-bit sampling at mid-bit.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shreg_d = shreg_q;
      fperr_d = fperr_q;
      fferr_d = fferr_q;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rxs) begin
               state_d = ST_START;
               s_d     = '0;
            end
         end
         ST_START: begin
            if (bus.sTick) begin
               if (s_q == S_MID) begin
                  if (!rxs) begin
                     state_d = ST_DATA;
                     s_d     = '0;
                     n_d     = '0;
                     fperr_d = 1'b0;
                     fferr_d = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         ST_DATA: begin
            if (bus.sTick) begin
               if (s_q == S_LAST) begin
                  shreg_d = {rxs, shreg_q[DBITS-1:1]};
                  s_d     = '0;
                  if (n_q == N_LAST) begin
                     n_d = '0;
                     if (PARITY_EN != 0) state_d = ST_PARITY;
                     else                state_d = ST_STOP;
                  end else begin
                     n_d = n_q + N_W'(1);
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (bus.sTick) begin
               if (s_q == S_LAST) begin
                  fperr_d = parity_bad((^shreg_q) ^ rxs, PAR_MODE);
                  state_d = ST_STOP;
                  s_d     = '0;
                  n_d     = '0;
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         ST_STOP: begin
            if (bus.sTick) begin
               if (s_q == S_LAST) begin
                  s_d = '0;
                  if (!rxs) fferr_d = 1'b1;
                  if (n_q == N_STOP_LAST) begin
                     done    = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     n_d = n_q + N_W'(1);
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Frame FSM registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         n_q     <= '0;
         shreg_q <= '0;
         fperr_q <= 1'b0;
         fferr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         shreg_q <= shreg_d;
         fperr_q <= fperr_d;
         fferr_q <= fferr_d;
      end
   end

   // Holding register: load on completion when free, else drop and flag overrun.
   always_comb begin
      rxdata_d  = rxdata_q;
      rxvalid_d = rxvalid_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      overrun_d = 1'b0;
      if (done) begin
         if (!rxvalid_q || bus.rxReady) begin
            rxdata_d  = shreg_q;
            perr_d    = fperr_q;
            ferr_d    = fferr_q | ~rxs;
            rxvalid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rxvalid_q && bus.rxReady) begin
         rxvalid_d = 1'b0;
      end
   end

   // Holding register flops.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rxdata_q  <= '0;
         rxvalid_q <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         rxdata_q  <= rxdata_d;
         rxvalid_q <= rxvalid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.rxData    = rxdata_q;
   assign bus.rxValid   = rxvalid_q;
   assign bus.parityErr = perr_q;
   assign bus.frameErr  = ferr_q;
   assign bus.overrun   = overrun_q;
   assign bus.busy      = (state_q != ST_IDLE);
endmodule
